elink_trig_voter: RTL and testbench
===================================

ELINK_TRIG_VOTER -- requirements
Module: elink_trig_voter

Interface
REQ-001 Parameter DATA_W, default 10, width of each e-link trigger word lane.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 data_in1  input  DATA_W  lane 1 copy of the trigger word.
REQ-005 data_in2  input  DATA_W  lane 2 copy of the trigger word.
REQ-006 data_in3  input  DATA_W  lane 3 copy of the trigger word.
REQ-007 voted  output  DATA_W+2 (12 by default)  registered result: [DATA_W-1:0] voted word, [DATA_W] mismatch flag, [DATA_W+1] multi-lane fault flag.

Function
REQ-008 Bit i of the voted word SHALL be the 2-of-3 majority of data_in1[i], data_in2[i], data_in3[i], for every i in 0..DATA_W-1.
REQ-009 Mismatch flag SHALL be 1 when any bit position has non-identical values across the three lanes, else 0.
REQ-010 Per disagreeing bit position, the minority lane SHALL be the single lane whose value differs from the other two.
REQ-011 Multi-lane fault flag SHALL be 1 when the disagreeing bit positions do not all share the same minority lane, else 0; it SHALL be 0 whenever mismatch flag is 0.
REQ-012 Mismatch and multi-lane flags SHALL be computed from the same input sample as the voted word.
REQ-013 voted SHALL be registered; latency exactly 1 clk cycle from inputs sampled at a rising edge to voted valid after that edge.
REQ-014 A new word SHALL be accepted every cycle; no handshake, no stall, no back-pressure.
REQ-015 Inputs SHALL be treated as synchronous to clk; no input synchronisers inside the block.
REQ-016 Output SHALL depend only on the most recent sampled inputs; no sticky or accumulated state.

Reset
REQ-017 While rst=1, voted SHALL be all zeros, asynchronously and independent of clk.
REQ-018 On rst deassertion, the first rising edge SHALL load voted from the current inputs normally.
REQ-019 rst asserted mid-stream SHALL clear voted immediately; no in-flight result is retained.

Structure
REQ-020 A shared package SHALL hold DATA_W default (10), output width DATA_W+2, and the flag bit indices (MISMATCH_BIT=DATA_W, MULTI_BIT=DATA_W+1).
REQ-021 One sub-module, maj3_slice, SHALL implement a single bit: majority output, disagreement flag, and one-hot 3-bit minority-lane indicator; elink_trig_voter instantiates DATA_W slices and reduces their flags.
REQ-022 Multi-lane detection SHALL be the OR-reduction of minority-lane indicators across slices having more than one bit set.

Verification
REQ-023 rst=1 with any inputs -> voted=0x000; deassert rst, next edge applies REQ-008..011.
REQ-024 data_in1=data_in2=data_in3=0x3FF -> voted=0x3FF one cycle later (flags 0).
REQ-025 data_in1=0x000, data_in2=0x3FF, data_in3=0x3FF -> voted=0x7FF (word 0x3FF, mismatch 1, multi 0).
REQ-026 data_in1=0x000, data_in2=0x000, data_in3=0x3FF -> voted=0x400 (word 0x000, mismatch 1, multi 0).
REQ-027 data_in1=0x001, data_in2=0x000, data_in3=0x3FF -> voted=0xC01 (word 0x001, mismatch 1, multi 1: bit0 minority lane 2, bits 1-9 minority lane 3).
REQ-028 Change inputs every cycle with clk period 2 ns and assert rst asynchronously mid-cycle -> voted tracks each input set with 1-cycle latency and drops to 0x000 immediately on rst.

Source files
------------

// File: rtl/elink_trig_voter_pkg.sv
// Shared constants and types for the e-link trigger-word triple-redundancy voter.
// Flag positions sit directly above the voted word in the output bus.
package elink_trig_voter_pkg;

    localparam int DATA_W_DEF       = 10;
    localparam int OUT_W_DEF        = DATA_W_DEF + 2;
    localparam int MISMATCH_BIT_DEF = DATA_W_DEF;
    localparam int MULTI_BIT_DEF    = DATA_W_DEF + 1;

    // One-hot minority-lane indicator produced per bit slice.
    typedef enum logic [2:0] {
        LANE_NONE = 3'b000,
        LANE_1    = 3'b001,
        LANE_2    = 3'b010,
        LANE_3    = 3'b100
    } lane_e;

    function automatic int out_w(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int mismatch_bit(input int data_w);
        return data_w;
    endfunction

    function automatic int multi_bit(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/elink_trig_voter_maj3_slice.sv
// Single-bit 2-of-3 voter: majority value, disagreement flag and one-hot minority lane.
// Purely combinational; the parent registers the result.
module maj3_slice
    import elink_trig_voter_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    output logic       maj_o,
    output logic       dis_o,
    output logic [2:0] minority_o
);

    lane_e lane;

    always_comb begin
        maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
        dis_o = !((a_i == b_i) && (b_i == c_i));
        lane  = LANE_NONE;
        // With three binary inputs, any disagreement leaves exactly one odd lane.
        if (dis_o) begin
            if (b_i == c_i) begin
                lane = LANE_1;
            end else if (a_i == c_i) begin
                lane = LANE_2;
            end else begin
                lane = LANE_3;
            end
        end
        minority_o = lane;
    end

endmodule

// File: rtl/elink_trig_voter.sv
// Bitwise 2-of-3 voter over three e-link trigger-word lanes with mismatch and multi-lane fault flags.
// One registered stage, accepts a word every cycle, no stall or back-pressure.
module elink_trig_voter
    import elink_trig_voter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    output logic [DATA_W+1:0] voted
);

    localparam int OUT_W        = out_w(DATA_W);
    localparam int MISMATCH_BIT = mismatch_bit(DATA_W);
    localparam int MULTI_BIT    = multi_bit(DATA_W);

    logic [DATA_W-1:0] word_d;
    logic [DATA_W-1:0] dis_vec;
    logic [2:0]        min_vec [DATA_W];
    logic [2:0]        lane_or;
    logic              mismatch_d;
    logic              multi_d;
    logic [OUT_W-1:0]  voted_d;
    logic [OUT_W-1:0]  voted_q;

    for (genvar i = 0; i < DATA_W; i++) begin : g_slice
        maj3_slice u_slice (
            .a_i        (data_in1[i]),
            .b_i        (data_in2[i]),
            .c_i        (data_in3[i]),
            .maj_o      (word_d[i]),
            .dis_o      (dis_vec[i]),
            .minority_o (min_vec[i])
        );
    end

    always_comb begin
        lane_or = 3'b000;
        for (int i = 0; i < DATA_W; i++) begin
            lane_or = lane_or | min_vec[i];
        end
        mismatch_d = |dis_vec;
        // More than one distinct minority lane seen across the word.
        multi_d    = (lane_or & (lane_or - 3'd1)) != 3'b000;
        voted_d                 = '0;
        voted_d[DATA_W-1:0]     = word_d;
        voted_d[MISMATCH_BIT]   = mismatch_d;
        voted_d[MULTI_BIT]      = multi_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_q <= '0;
        end else begin
            voted_q <= voted_d;
        end
    end

    assign voted = voted_q;

endmodule

// File: tb/tb_elink_trig_voter.sv
// Directed and randomized checks of elink_trig_voter against a per-bit counting model.
`timescale 1ns/100ps
module tb_elink_trig_voter;

    localparam int DW = 10;
    localparam int OW = DW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in1 = '0;
    logic [DW-1:0] data_in2 = '0;
    logic [DW-1:0] data_in3 = '0;
    logic [OW-1:0] voted;

    int checks = 0;
    int errors = 0;

    always #1 clk = ~clk;

    elink_trig_voter #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_in3 (data_in3),
        .voted    (voted)
    );

    // Count ones per bit; the minority lane is the one holding the rarer value.
    function automatic logic [OW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
        logic [OW-1:0] r;
        bit            seen [3];
        int            cnt, nseen, odd;
        logic [2:0]    v;
        r = '0;
        seen = '{0, 0, 0};
        for (int i = 0; i < DW; i++) begin
            v   = {c[i], b[i], a[i]};
            cnt = int'(v[0]) + int'(v[1]) + int'(v[2]);
            r[i] = (cnt >= 2);
            if (cnt == 1 || cnt == 2) begin
                r[DW] = 1'b1;
                odd = (cnt == 1) ? 1 : 0;
                for (int l = 0; l < 3; l++)
                    if (int'(v[l]) == odd) seen[l] = 1;
            end
        end
        nseen = int'(seen[0]) + int'(seen[1]) + int'(seen[2]);
        r[DW+1] = (nseen > 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample just after the next rising edge.
    task automatic apply(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        @(negedge clk);
        data_in1 = a;
        data_in2 = b;
        data_in3 = c;
        @(posedge clk);
        #0.5;
    endtask

    task automatic rand_word(output logic [DW-1:0] a, output logic [DW-1:0] b,
                             output logic [DW-1:0] c);
        a = DW'($urandom);
        case ($urandom_range(0, 3))
            0: begin b = a; c = a; end
            1: begin b = a; c = a ^ DW'($urandom); end
            2: begin b = a ^ (DW'(1) << $urandom_range(0, DW-1)); c = a; end
            default: begin b = DW'($urandom); c = DW'($urandom); end
        endcase
    endtask

    logic [DW-1:0] ra, rb, rc;
    logic [OW-1:0] prev_exp;

    initial begin
        data_in1 = DW'($urandom);
        data_in2 = DW'($urandom);
        data_in3 = DW'($urandom);
        #0.5;
        check("reset_initial", voted, '0);
        apply(10'h155, 10'h2AA, 10'h0F0);
        check("reset_held_clocked", voted, '0);

        @(negedge clk);
        rst = 1'b0;
        apply(10'h3FF, 10'h3FF, 10'h3FF);
        check("all_ones", voted, 12'h3FF);
        apply(10'h000, 10'h3FF, 10'h3FF);
        check("lane1_minority", voted, 12'h7FF);
        apply(10'h000, 10'h000, 10'h3FF);
        check("lane3_minority", voted, 12'h400);
        apply(10'h001, 10'h000, 10'h3FF);
        check("multi_lane", voted, 12'hC01);
        apply(10'h000, 10'h000, 10'h000);
        check("all_zero_no_sticky", voted, 12'h000);
        apply(10'h200, 10'h000, 10'h000);
        check("msb_single_flip", voted, 12'h400);
        apply(10'h3FF, 10'h3FE, 10'h3FF);
        check("lane2_minority", voted, 12'h7FF);

        // Randomised stream, new word every cycle.
        for (int n = 0; n < 300; n++) begin
            rand_word(ra, rb, rc);
            apply(ra, rb, rc);
            check("random", voted, model(ra, rb, rc));
        end

        // Asynchronous reset mid-stream, asserted between clock edges.
        for (int k = 0; k < 4; k++) begin
            rand_word(ra, rb, rc);
            apply(ra, rb, rc);
            check("pre_reset", voted, model(ra, rb, rc));
            #0.2;
            rst = 1'b1;
            #0.1;
            check("async_reset_clear", voted, '0);
            rand_word(ra, rb, rc);
            apply(ra, rb, rc);
            check("reset_hold", voted, '0);
            @(negedge clk);
            rst = 1'b0;
            rand_word(ra, rb, rc);
            data_in1 = ra;
            data_in2 = rb;
            data_in3 = rc;
            prev_exp = model(ra, rb, rc);
            @(posedge clk);
            #0.5;
            check("first_after_reset", voted, prev_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
